// File: rtl/ps2_kbd_tx_pkg.sv
// ps2_pkg: shared states, frame constants and frame builder for the PS/2 device transmitter.
package ps2_pkg;
    typedef enum logic [2:0] {PS2_IDLE, PS2_LOAD, PS2_BIT_HI, PS2_BIT_LO, PS2_GAP} ps2_state_e;
    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_LAST_BIT = 10;
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction
endpackage

// File: rtl/ps2_kbd_tx_if.sv
// ps2_kbd_tx_if: scancode byte handshake between the scancode source and the PS/2 transmitter.
interface ps2_kbd_tx_if;
    logic [7:0] kbd_data;
    logic kbd_valid;
    logic kbd_ready;
    modport master(output kbd_data, output kbd_valid, input kbd_ready);
    modport slave(input kbd_data, input kbd_valid, output kbd_ready);
endinterface

// File: rtl/ps2_kbd_tx_fifo.sv
// ps2_tx_fifo: byte FIFO buffering scancode bursts; full flag is registered.
module ps2_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk_sys,
    input  logic       RESET_n,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic [7:0] dout_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q, cnt_d;
    logic full_q;
    assign cnt_d = cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    assign dout_o = mem_q[rd_q];
    assign full_o = full_q;
    assign empty_o = cnt_q == '0;
    always_ff @(posedge clk_sys or negedge RESET_n)
        if (!RESET_n) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            full_q <= 1'b0;
        end else begin
            wr_q <= push_i ? wr_q + AW'(1) : wr_q;
            rd_q <= pop_i ? rd_q + AW'(1) : rd_q;
            cnt_q <= cnt_d;
            full_q <= cnt_d == (AW+1)'(DEPTH);
        end
    always_ff @(posedge clk_sys)
        if (push_i) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: PS/2 device-side transmitter serialising buffered scancodes onto clock/data lines.
// Define PS2_TX_INHIBIT_EN to honour host inhibit on ps2_clk_in (abort and resend).
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int HALF_PERIOD = 640,
    parameter int GAP_HALVES = 4,
    parameter int DEPTH = 8
) (
    input  logic         clk_sys,
    input  logic         RESET_n,
    input  logic         ce,
    ps2_kbd_tx_if.slave  kbd,
    input  logic         ps2_clk_in,
    output logic         ps2_clk,
    output logic         ps2_data,
    output logic         busy
);
    localparam int CW = $clog2(GAP_HALVES * HALF_PERIOD + 1);
    localparam logic [CW-1:0] HP_LD = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] GAP_LD = CW'(GAP_HALVES * HALF_PERIOD - 1);
    localparam logic [3:0] LAST = 4'(PS2_LAST_BIT);
    localparam logic [2:0] S_IDLE = PS2_IDLE;
    localparam logic [2:0] S_LOAD = PS2_LOAD;
    localparam logic [2:0] S_BIT_HI = PS2_BIT_HI;
    localparam logic [2:0] S_BIT_LO = PS2_BIT_LO;
    localparam logic [2:0] S_GAP = PS2_GAP;
    logic [2:0] state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] bit_q, bit_d;
    logic [7:0] retry_q, retry_d;
    logic rpend_q, rpend_d, clk_q, clk_d, data_q, data_d;
    logic inh, tick, pop, full, empty;
    logic [7:0] head;
    logic [PS2_FRAME_BITS-1:0] frame;
    ps2_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_sys(clk_sys), .RESET_n(RESET_n),
        .push_i(kbd.kbd_valid & ~full), .din_i(kbd.kbd_data), .pop_i(pop),
        .dout_o(head), .full_o(full), .empty_o(empty)
    );
`ifdef PS2_TX_INHIBIT_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk_sys or negedge RESET_n)
        if (!RESET_n) sync_q <= 2'b11;
        else sync_q <= {sync_q[0], ps2_clk_in};
    assign inh = ~sync_q[1];
`else
    logic unused_clk_in;
    assign unused_clk_in = ps2_clk_in;
    assign inh = 1'b0;
`endif
    assign kbd.kbd_ready = ~full;
    assign frame = ps2_frame(retry_q);
    assign tick = ce && cnt_q == '0;
    assign ps2_clk = clk_q;
    assign ps2_data = data_q;
    assign busy = state_q != S_IDLE;
    always_comb begin
        state_d = state_q;
        cnt_d = (ce && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        bit_d = bit_q;
        retry_d = retry_q;
        rpend_d = rpend_q;
        clk_d = clk_q;
        data_d = data_q;
        pop = 1'b0;
        case (state_q)
            S_IDLE: state_d = (ce && !inh && (rpend_q || !empty)) ? S_LOAD : S_IDLE;
            // The popped byte lives in retry_q until the frame is done, so an abort can resend it.
            S_LOAD: if (ce) begin
                pop = !rpend_q;
                retry_d = rpend_q ? retry_q : head;
                rpend_d = 1'b0;
                bit_d = '0;
                data_d = 1'b0;
                cnt_d = HP_LD;
                state_d = S_BIT_HI;
            end
            S_BIT_HI: if (tick) begin
                clk_d = 1'b0;
                cnt_d = HP_LD;
                state_d = S_BIT_LO;
            end
            S_BIT_LO: if (tick) begin
                clk_d = 1'b1;
                cnt_d = bit_q == LAST ? GAP_LD : HP_LD;
                state_d = bit_q == LAST ? S_GAP : S_BIT_HI;
                bit_d = bit_q == LAST ? bit_q : bit_q + 4'd1;
                data_d = frame[bit_d];
            end
            S_GAP: state_d = (tick && !inh) ? S_IDLE : S_GAP;
            default: state_d = S_IDLE;
        endcase
        if (inh && (state_q == S_BIT_HI || state_q == S_BIT_LO)) begin
            state_d = S_GAP;
            clk_d = 1'b1;
            data_d = 1'b1;
            cnt_d = GAP_LD;
            rpend_d = bit_q != LAST;
        end
    end
    always_ff @(posedge clk_sys or negedge RESET_n)
        if (!RESET_n) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            retry_q <= '0;
            rpend_q <= 1'b0;
            clk_q <= 1'b1;
            data_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            retry_q <= retry_d;
            rpend_q <= rpend_d;
            clk_q <= clk_d;
            data_q <= data_d;
        end
endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb_ps2_kbd_tx: scoreboard bench; a line monitor decodes PS/2 frames and checks them against accepted bytes.
module tb_ps2_kbd_tx;
    localparam int HP = 4;
    localparam int GH = 4;
    localparam int DP = 8;
    logic clk_sys = 1'b0;
    logic RESET_n = 1'b0;
    logic ce = 1'b0;
    logic ps2_clk_in = 1'b1;
    logic ps2_clk, ps2_data, busy;
    ps2_kbd_tx_if kif();
    ps2_kbd_tx #(.HALF_PERIOD(HP), .GAP_HALVES(GH), .DEPTH(DP)) dut (
        .clk_sys(clk_sys), .RESET_n(RESET_n), .ce(ce), .kbd(kif),
        .ps2_clk_in(ps2_clk_in), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy)
    );
    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    int runs_q[$];
    int mode = 0;
    bit allow_partial = 1'b0;
    int nbits = 0, hi = 0, bh = 0, cyc = 0, start_cyc = 0, falls = 0;
    logic p_clk = 1'b1, p_data = 1'b1;
    bit all_ce = 1'b0;
    logic [10:0] fb = '0;
    always #5 clk_sys = ~clk_sys;
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask
    // Reference frame: start 0, data LSB first, odd parity over data+parity, stop 1.
    function automatic int model_frame(input logic [7:0] b);
        int ones;
        ones = $countones(b);
        return (1 << 10) | (((ones % 2) == 0 ? 1 : 0) << 9) | (int'(b) << 1);
    endfunction
    initial forever begin
        @(posedge clk_sys);
        #1;
        ce = (mode == 1) || (mode == 2 && $urandom_range(2) == 0);
    end
    always @(negedge clk_sys) begin
        cyc++;
        if (ps2_clk && !ps2_data && p_data && nbits == 0) begin
            runs_q.push_back(bh);
            start_cyc = cyc;
            all_ce = 1'b1;
        end
        if (!ce) all_ce = 1'b0;
        bh = (ps2_clk && ps2_data) ? bh + 1 : 0;
        if (p_clk && !ps2_clk) begin
            fb = {ps2_data, fb[10:1]};
            nbits++;
            falls++;
        end
        if (!p_clk && ps2_clk && nbits == 11 && all_ce) check("frame_cycles", cyc - start_cyc, 22 * HP);
        hi = !ps2_clk ? 0 : (ce ? hi + 1 : hi);
        if (hi > HP && nbits != 0) begin
            if (nbits == 11) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL frame_extra: got 0x%0h expected no frame", fb);
                end else check("frame", int'(fb), model_frame(exp_q.pop_front()));
            end else if (!allow_partial) check("frame_falls", nbits, 11);
            nbits = 0;
        end
        p_clk = ps2_clk;
        p_data = ps2_data;
    end
    task automatic push(input logic [7:0] b, input int tmo, output bit ok);
        ok = 1'b0;
        kif.kbd_data = b;
        kif.kbd_valid = 1'b1;
        for (int i = 0; i < tmo && !ok; i++) begin
            ok = kif.kbd_ready;
            @(posedge clk_sys);
            #1;
        end
        kif.kbd_valid = 1'b0;
        if (ok) exp_q.push_back(b);
    endtask
    task automatic wait_drain(input int tmo);
        for (int i = 0; i < tmo && !(exp_q.size() == 0 && !busy); i++) begin
            @(posedge clk_sys);
            #1;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask
    task automatic wait_nbits(input int n, input int tmo);
        for (int i = 0; i < tmo && nbits != n; i++) begin
            @(posedge clk_sys);
            #1;
        end
        check("wait_bits", nbits, n);
    endtask
    initial begin
        bit ok;
        int acc, f0;
        logic [7:0] base;
        kif.kbd_valid = 1'b0;
        kif.kbd_data = '0;
        #12;
        check("rst_clk", ps2_clk, 1);
        check("rst_data", ps2_data, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", kif.kbd_ready, 1);
        @(posedge clk_sys);
        #1;
        RESET_n = 1'b1;
        mode = 1;
        repeat (3) @(posedge clk_sys);
        #1;
        push(8'h1C, 20, ok);
        check("accept_1c", ok, 1);
        @(posedge clk_sys);
        #1;
        check("start_lat_1", ps2_data, 1);
        @(posedge clk_sys);
        #1;
        check("start_lat_2", ps2_data, 0);
        wait_drain(1000);
        check("busy_after_gap", busy, 0);
        runs_q.delete();
        push(8'hF0, 20, ok);
        push(8'h1C, 20, ok);
        wait_drain(2000);
        check("gap_run", runs_q.size() >= 2 ? runs_q[1] : -1, GH * HP + 2);
        mode = 0;
        repeat (4) @(posedge clk_sys);
        #1;
        acc = 0;
        base = 8'($urandom);
        for (int i = 0; i < 10; i++) begin
            push(base + 8'(i * 29), 20, ok);
            acc += int'(ok);
        end
        check("stall_accepts", acc, DP);
        check("ready_full", kif.kbd_ready, 0);
        mode = 1;
        for (int i = 0; i < 20 && !busy; i++) begin
            @(posedge clk_sys);
            #1;
        end
        check("ready_at_load", kif.kbd_ready, 0);
        @(posedge clk_sys);
        #1;
        check("ready_after_pop", kif.kbd_ready, 1);
        mode = 2;
        wait_drain(20000);
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(30)) @(posedge clk_sys);
            #1;
            push(8'($urandom), 2000, ok);
            check("rand_accept", ok, 1);
        end
        wait_drain(40000);
        mode = 1;
        push(8'hA5, 20, ok);
        wait_nbits(5, 500);
        check("pre_rst_clk", ps2_clk, 0);
        RESET_n = 1'b0;
        #1;
        check("mid_rst_clk", ps2_clk, 1);
        check("mid_rst_data", ps2_data, 1);
        check("mid_rst_ready", kif.kbd_ready, 1);
        check("mid_rst_busy", busy, 0);
        exp_q.delete();
        nbits = 0;
        f0 = falls;
        repeat (3) @(posedge clk_sys);
        #1;
        RESET_n = 1'b1;
        repeat (60) @(posedge clk_sys);
        #1;
        check("falls_after_rst", falls - f0, 0);
`ifdef PS2_TX_INHIBIT_EN
        allow_partial = 1'b1;
        push(8'h5A, 20, ok);
        wait_nbits(4, 500);
        ps2_clk_in = 1'b0;
        repeat (10) @(posedge clk_sys);
        #1;
        check("abort_lines", {ps2_clk, ps2_data}, 2'b11);
        repeat (90) @(posedge clk_sys);
        #1;
        ps2_clk_in = 1'b1;
        wait_drain(2000);
        allow_partial = 1'b0;
        push(8'h11, 20, ok);
        push(8'h22, 20, ok);
        wait_nbits(11, 500);
        ps2_clk_in = 1'b0;
        repeat (20) @(posedge clk_sys);
        #1;
        ps2_clk_in = 1'b1;
        wait_drain(2000);
`endif
        repeat (10) @(posedge clk_sys);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ps2_kbd_tx.md
# ps2_kbd_tx

PS/2 device-side transmitter. It serialises keyboard scancode bytes into a PS/2 clock/data waveform for the motherboard's PS/2 receiver. It sits between the scancode source and the motherboard `PS2_CLK`/`PS2_DATA` inputs, and can replace the HPS-generated serial stream. A small FIFO buffers bursts such as multi-byte break codes. Frames are paced from a clock enable.

## Interface
Parameters:
- `HALF_PERIOD`, default 640: `ce` ticks per PS/2 clock half-period. The default gives 40 µs at a 16 MHz `ce`.
- `GAP_HALVES`, default 4: idle half-periods inserted after each frame.
- `DEPTH`, default 8: FIFO entries. Must be a power of two, 2..32.

Ports (name, direction, width, meaning):
- `clk_sys` in 1: the single clock. All logic is on the rising edge.
- `RESET_n` in 1: asynchronous, active-low reset.
- `ce` in 1: pacing enable, one `clk_sys` cycle wide.
- `kbd_data` in 8: scancode byte to send.
- `kbd_valid` in 1: `kbd_data` is valid.
- `kbd_ready` out 1: FIFO can accept a byte.
- `ps2_clk_in` in 1: host clock-line sense, used for inhibit. Ignored unless `PS2_TX_INHIBIT_EN` is defined.
- `ps2_clk` out 1: PS/2 clock. Idles high.
- `ps2_data` out 1: PS/2 data. Idles high.
- `busy` out 1: a frame or the post-frame gap is in progress.

## Operation
- Push rule: a byte enters the FIFO on any cycle with `kbd_valid & kbd_ready`.
- `kbd_ready` is the registered inverse of "FIFO full". A push attempted while full is blocked and nothing is dropped.
- Frame format, 11 bits in order:
  - start bit 0;
  - `data[0]` through `data[7]`, LSB first;
  - odd parity, equal to `~^data`;
  - stop bit 1.
- States:
  - IDLE: FIFO empty, or waiting.
  - LOAD: pop the FIFO head into the shift register; `bit_idx` = 0.
  - BIT_HI: drive the current bit on `ps2_data` with `ps2_clk` = 1 for `HALF_PERIOD` ticks.
  - BIT_LO: `ps2_clk` = 0 for `HALF_PERIOD` ticks.
  - GAP: both lines high for `GAP_HALVES * HALF_PERIOD` ticks.
- Transitions:
  - IDLE → LOAD when the FIFO is not empty.
  - LOAD → BIT_HI.
  - BIT_HI → BIT_LO when the half-period counter expires.
  - BIT_LO → BIT_HI when the counter expires and `bit_idx` < 10; `bit_idx` then increments.
  - BIT_LO → GAP when `bit_idx` = 10.
  - GAP → IDLE when the gap counter expires.
- `ps2_data` changes only on entry to BIT_HI, so it is stable across every falling edge of `ps2_clk`.
- The half-period counter reloads on every state entry and decrements only when `ce` is high.
- The head byte is popped in LOAD but kept in a retry register until the frame completes.

## Timing
- Reset values:
  - `ps2_clk` = 1, `ps2_data` = 1, `busy` = 0.
  - `kbd_ready` = 1, FIFO empty.
  - State IDLE, all counters 0.
- Push into an empty FIFO while IDLE: LOAD follows 1 cycle later. `ps2_data` falls (start bit) 2 cycles after acceptance.
- First `ps2_clk` fall: `HALF_PERIOD` `ce` ticks after entering BIT_HI.
- Full frame duration: 22 × `HALF_PERIOD` ticks, plus `GAP_HALVES` × `HALF_PERIOD` ticks of gap.
- Back-to-back bytes: the next LOAD comes 1 cycle after GAP ends.
- Push and pop in the same cycle: both take effect. The count is unchanged.
- Push while full: blocked. `kbd_ready` rises 1 cycle after the pop that frees an entry.
- Pointers wrap modulo `DEPTH`.
- `ce` held low: the state and both line outputs freeze.
- `RESET_n` asserted mid-frame:
  - immediately forces the reset values;
  - FIFO contents are lost;
  - no partial-frame completion.

## Configuration
`PS2_TX_INHIBIT_EN` selects host-inhibit support.

With the macro defined:
- `ps2_clk_in` passes through a 2-flop synchroniser.
- Sync low during IDLE or GAP: transmission is held off and stays held while the line is low.
- Sync low during BIT_HI or BIT_LO with `bit_idx` ≤ 9: the frame aborts.
  - Both lines go high and the state goes to GAP.
  - The retry register is resent next instead of the FIFO head.
- Sync low at `bit_idx` = 10: the byte counts as sent.

Without the macro:
- `ps2_clk_in` is unused and the synchroniser is absent.
- Frames are never aborted.

## Structure
- Package `ps2_pkg` holds:
  - the state enum (`PS2_IDLE`, `PS2_LOAD`, `PS2_BIT_HI`, `PS2_BIT_LO`, `PS2_GAP`);
  - `PS2_FRAME_BITS` = 11;
  - `PS2_LAST_BIT` = 10.
- Sub-module `ps2_tx_fifo`:
  - byte FIFO of `DEPTH` entries;
  - push/pop ports and full/empty flags;
  - an occupancy count one bit wider than the pointer.
- Serialiser, counters and inhibit logic live in the top module.

## Test plan
- Reset, then push 0x1C (`HALF_PERIOD` = 4, `ce` = 1):
  - `ps2_data` sequence on the falling edges is 0, 0,0,1,1,1,0,0,0, parity 0, stop 1;
  - exactly 11 `ps2_clk` falls;
  - `busy` drops after the gap.
- Push 0xF0 then 0x1C in consecutive cycles:
  - two frames are sent, separated by exactly `GAP_HALVES` × `HALF_PERIOD` ticks of both lines high.
- Hold `kbd_valid` with 10 distinct bytes and the serialiser stalled by `ce` = 0:
  - `kbd_ready` = 0 after 8 accepts;
  - the stream later shows exactly the first 8 bytes in order, none lost.
- Assert `RESET_n` = 0 at bit 5 of a frame:
  - both lines are high on the same cycle;
  - `kbd_ready` = 1;
  - no further clock edges.
- With `PS2_TX_INHIBIT_EN`, pull `ps2_clk_in` low at bit 4 of 0x5A, release after 100 cycles:
  - the frame aborts;
  - after the gap, a complete 0x5A frame is sent.
- With `PS2_TX_INHIBIT_EN`, pull `ps2_clk_in` low during the stop bit:
  - no retransmission;
  - the next FIFO byte follows.
